// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and address helpers for the fetch/memory RAM port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned RAM_WORD_W = 7;
    localparam int unsigned WORD_LSB   = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_MEM  = 2'd2
    } owner_e;

    function automatic logic [RAM_WORD_W-1:0] word_of(input logic [31:0] addr);
        return addr[WORD_LSB +: RAM_WORD_W];
    endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Memory-stage-first priority select with a saturating fetch starvation counter.
module arb_priority_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic mem_req,
    input  logic grant,
    output logic grant_if,
    output logic grant_mem
);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starved;

    assign starved = {28'd0, starve_cnt_q} >= STARVE_MAX;

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (grant) begin
            if (if_req && (!mem_req || starved)) begin
                grant_if = 1'b1;
            end else if (mem_req) begin
                grant_mem = 1'b1;
            end
        end
    end

    // Only mem grants that made fetch wait count towards starvation.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_mem && if_req && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between fetch (read-only) and memory stage (read/write),
// sequencing IDLE -> ACCESS (LATENCY cycles) -> RESP with a registered ack pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_stall,
    output logic [RAM_WORD_W-1:0] ram_addr,
    inout  wire  [31:0]           ram_data,
    output logic                  ram_wre
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [RAM_WORD_W-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           if_rdata_q, if_rdata_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  mem_ack_q, mem_ack_d;
    logic                  grant_if, grant_mem, last_access;
    logic                  unused_addr_bits;

    // Byte offset and high bits alias onto the same word.
    assign unused_addr_bits = ^{if_addr[31:WORD_LSB+RAM_WORD_W], if_addr[WORD_LSB-1:0],
                                mem_addr[31:WORD_LSB+RAM_WORD_W], mem_addr[WORD_LSB-1:0]};

    arb_priority_sel #(
        .STARVE_MAX(STARVE_MAX)
    ) u_priority_sel (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .mem_req  (mem_req),
        .grant    (state_q == ARB_IDLE),
        .grant_if (grant_if),
        .grant_mem(grant_mem)
    );

    assign last_access = (state_q == ARB_ACCESS) && (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_if) begin
                    owner_d = OWNER_IF;
                    addr_d  = word_of(if_addr);
                    we_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = ARB_ACCESS;
                end else if (grant_mem) begin
                    owner_d = OWNER_MEM;
                    addr_d  = word_of(mem_addr);
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (last_access) begin
                    state_d = ARB_RESP;
                    if (!we_q) begin
                        if (owner_q == OWNER_IF) begin
                            if_rdata_d = ram_data;
                        end else begin
                            mem_rdata_d = ram_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ARB_RESP: begin
                if_ack_d  = (owner_q == OWNER_IF);
                mem_ack_d = (owner_q == OWNER_MEM);
                owner_d   = OWNER_NONE;
                state_d   = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_NONE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wre   = last_access && we_q;
    assign ram_data  = ram_wre ? wdata_q : 32'bz;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign mem_stall = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (LATENCY 1 and 4) share stimulus,
// each with its own RAM model.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;

    logic [31:0] if_rdata1, mem_rdata1, if_rdata4, mem_rdata4;
    logic        if_ack1, if_stall1, mem_ack1, mem_stall1, ram_wre1;
    logic        if_ack4, if_stall4, mem_ack4, mem_stall4, ram_wre4;
    logic [6:0]  ram_addr1, ram_addr4;
    wire  [31:0] ram_data1, ram_data4;

    logic [31:0] ram1 [128];
    logic [31:0] ram4 [128];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int wre1_cnt = 0, wre4_cnt = 0;
    logic [6:0] last_wre_addr1 = '0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    mem_port_arbiter #(.LATENCY(1), .STARVE_MAX(3)) dut1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ack(if_ack1),
        .if_stall(if_stall1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata1), .mem_ack(mem_ack1), .mem_stall(mem_stall1),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_wre(ram_wre1)
    );

    mem_port_arbiter #(.LATENCY(4), .STARVE_MAX(3)) dut4 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata4), .if_ack(if_ack4),
        .if_stall(if_stall4),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata4), .mem_ack(mem_ack4), .mem_stall(mem_stall4),
        .ram_addr(ram_addr4), .ram_data(ram_data4), .ram_wre(ram_wre4)
    );

    assign ram_data1 = ram_wre1 ? 32'bz : ram1[ram_addr1];
    assign ram_data4 = ram_wre4 ? 32'bz : ram4[ram_addr4];

    always @(posedge clock) begin
        if (pre_we) begin
            ram1[pre_addr] <= pre_data;
            ram4[pre_addr] <= pre_data;
        end
        if (ram_wre1) ram1[ram_addr1] <= ram_data1;
        if (ram_wre4) ram4[ram_addr4] <= ram_data4;
    end

    always @(negedge clock) begin
        if (ram_wre1) begin
            wre1_cnt       <= wre1_cnt + 1;
            last_wre_addr1 <= ram_addr1;
        end
        if (ram_wre4) wre4_cnt <= wre4_cnt + 1;
    end

    function automatic void push_exp(input bit is_if, input logic [31:0] data, input int cyc);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        e.cycle = cyc;
        sb.push_back(e);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic preload(input logic [6:0] w, input logic [31:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = w; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Waits (bounded) for the next ack on one instance; k = negedges waited.
    task automatic wait_ack(input bit on4, input int limit, output bit gi, output bit gm,
                            output int k);
        gi = 1'b0; gm = 1'b0; k = 0;
        while (k < limit && !gi && !gm) begin
            @(negedge clock);
            k++;
            gi = on4 ? if_ack4 : if_ack1;
            gm = on4 ? mem_ack4 : mem_ack1;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        #1;
        checks++;
        if (if_ack1 !== 1'b0 || mem_ack1 !== 1'b0) begin
            errors++; $display("FAIL reset_acks: got %b%b want 00", if_ack1, mem_ack1);
        end
        checks++;
        if (if_rdata1 !== 32'h0 || mem_rdata1 !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata1, mem_rdata1);
        end
        checks++;
        if (ram_addr1 !== 7'd0 || ram_wre1 !== 1'b0) begin
            errors++; $display("FAIL reset_ram: got addr %h wre %b want 0 0", ram_addr1, ram_wre1);
        end
        checks++;
        if (ram_addr4 !== 7'd0 || ram_wre4 !== 1'b0 || if_ack4 !== 1'b0 || mem_ack4 !== 1'b0) begin
            errors++; $display("FAIL reset_dut4: got addr %h wre %b acks %b%b want 0 0 00",
                               ram_addr4, ram_wre4, if_ack4, mem_ack4);
        end
        if_req = 1'b1; mem_req = 1'b1;
        #1;
        checks++;
        if (if_stall1 !== 1'b1 || mem_stall1 !== 1'b1) begin
            errors++; $display("FAIL reset_stall: got %b%b want 11", if_stall1, mem_stall1);
        end
        if_req = 1'b0; mem_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (ram_wre1 !== 1'b0 || if_ack1 !== 1'b0 || mem_ack1 !== 1'b0 || ram_addr1 !== 7'd0) begin
            errors++; $display("FAIL idle_quiet: got wre %b acks %b%b addr %h want 0 00 0",
                               ram_wre1, if_ack1, mem_ack1, ram_addr1);
        end
    endtask

    task automatic test_fetch_read();
        exp_t e;
        int k, stall_bad, mem_bad, extra;
        bit got;
        do_reset();
        preload(7'd5, 32'hDEAD_BEEF);
        push_exp(1'b1, 32'hDEAD_BEEF, 3);
        if_req = 1'b1; if_addr = 32'h14;
        k = 0; stall_bad = 0; mem_bad = 0; got = 1'b0;
        while (k < 10 && !got) begin
            @(negedge clock);
            k++;
            if (mem_ack1) mem_bad++;
            if (if_ack1) begin
                got = 1'b1;
                if (if_stall1 !== 1'b0) stall_bad++;
            end else if (if_stall1 !== 1'b1) begin
                stall_bad++;
            end
        end
        if_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!got || k != e.cycle) begin
            errors++; $display("FAIL fetch_ack_latency: got cycle %0d (ack %b) want %0d", k, got,
                               e.cycle);
        end
        checks++;
        if (if_rdata1 !== e.data) begin
            errors++; $display("FAIL fetch_rdata: got %h want %h", if_rdata1, e.data);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL fetch_stall: got %0d bad cycles want 0", stall_bad);
        end
        extra = 0;
        repeat (5) begin
            @(negedge clock);
            if (if_ack1 || mem_ack1) extra++;
        end
        checks++;
        if (extra != 0 || mem_bad != 0) begin
            errors++; $display("FAIL fetch_single_ack: got %0d extra %0d mem want 0 0", extra,
                               mem_bad);
        end
    endtask

    task automatic test_write();
        exp_t e;
        int k, w0;
        bit gi, gm;
        do_reset();
        w0 = wre1_cnt;
        push_exp(1'b0, 32'h0, 3);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h1234_5678;
        wait_ack(1'b0, 10, gi, gm, k);
        mem_req = 1'b0; mem_we = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!gm || gi || k != e.cycle) begin
            errors++; $display("FAIL write_ack: got mem %b if %b cycle %0d want 1 0 %0d", gm, gi,
                               k, e.cycle);
        end
        checks++;
        if (wre1_cnt - w0 != 1 || last_wre_addr1 !== 7'd8) begin
            errors++; $display("FAIL write_strobe: got %0d pulses addr %h want 1 pulse addr 08",
                               wre1_cnt - w0, last_wre_addr1);
        end
        checks++;
        if (mem_rdata1 !== e.data) begin
            errors++; $display("FAIL write_no_rdata: got %h want %h", mem_rdata1, e.data);
        end
        push_exp(1'b1, 32'h1234_5678, 3);
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h20;
        wait_ack(1'b0, 10, gi, gm, k);
        if_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!gi || if_rdata1 !== e.data) begin
            errors++; $display("FAIL write_readback: got %h (ack %b) want %h", if_rdata1, gi,
                               e.data);
        end
        checks++;
        if (mem_rdata1 !== 32'h0) begin
            errors++; $display("FAIL write_mem_rdata_hold: got %h want 00000000", mem_rdata1);
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        int k;
        bit gi, gm;
        do_reset();
        preload(7'd2, 32'hA5A5_0002);
        for (int n = 0; n < 8; n++) begin
            if (n == 3 || n == 7) push_exp(1'b1, 32'hDEAD_BEEF, 3);
            else push_exp(1'b0, 32'hA5A5_0002, 3);
        end
        if_req = 1'b1; if_addr = 32'h14;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8;
        for (int n = 0; n < 8; n++) begin
            wait_ack(1'b0, 6, gi, gm, k);
            e = sb.pop_front();
            checks++;
            if (!(gi || gm) || gi != e.is_if || k != e.cycle) begin
                errors++; $display("FAIL grant_order[%0d]: got if %b mem %b cycle %0d want if %b cycle %0d",
                                   n, gi, gm, k, e.is_if, e.cycle);
            end
            checks++;
            if ((e.is_if ? if_rdata1 : mem_rdata1) !== e.data) begin
                errors++; $display("FAIL grant_data[%0d]: got %h want %h", n,
                                   e.is_if ? if_rdata1 : mem_rdata1, e.data);
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
    endtask

    task automatic test_latency4();
        exp_t e;
        int k, bad;
        bit gi, gm;
        do_reset();
        preload(7'd3, 32'hCAFE_0003);
        push_exp(1'b1, 32'hCAFE_0003, 6);
        push_exp(1'b1, 32'hCAFE_0003, 6);
        if_req = 1'b1; if_addr = 32'hC;
        k = 0; bad = 0; gi = 1'b0;
        while (k < 12 && !gi) begin
            @(negedge clock);
            k++;
            gi = if_ack4;
            if (k <= 4 && ram_addr4 !== 7'd3) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL lat4_addr_stable: got %0d bad cycles want 0", bad);
        end
        e = sb.pop_front();
        checks++;
        if (!gi || k != e.cycle || if_rdata4 !== e.data) begin
            errors++; $display("FAIL lat4_first: got cycle %0d data %h want cycle %0d data %h",
                               k, if_rdata4, e.cycle, e.data);
        end
        wait_ack(1'b1, 12, gi, gm, k);
        e = sb.pop_front();
        checks++;
        if (!gi || k != e.cycle) begin
            errors++; $display("FAIL lat4_b2b_spacing: got %0d want %0d", k, e.cycle);
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset_during_access();
        exp_t e;
        int k, w0;
        bit gi, gm;
        do_reset();
        w0 = wre4_cnt;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h5555_AAAA;
        repeat (2) @(negedge clock);
        checks++;
        if (ram_addr4 !== 7'd16) begin
            errors++; $display("FAIL rst_access_addr: got %h want 10", ram_addr4);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ram_addr4 !== 7'd0 || ram_wre4 !== 1'b0 || mem_ack4 !== 1'b0 || if_ack4 !== 1'b0) begin
            errors++; $display("FAIL rst_async: got addr %h wre %b acks %b%b want 0 0 00",
                               ram_addr4, ram_wre4, if_ack4, mem_ack4);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (wre4_cnt != w0) begin
            errors++; $display("FAIL rst_no_wre: got %0d pulses want 0", wre4_cnt - w0);
        end
        push_exp(1'b0, 32'h0, 6);
        reset = 1'b1;
        wait_ack(1'b1, 12, gi, gm, k);
        mem_req = 1'b0; mem_we = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!gm || k != e.cycle || mem_rdata4 !== e.data) begin
            errors++; $display("FAIL rst_rearb: got ack %b cycle %0d rdata %h want 1 %0d %h", gm,
                               k, mem_rdata4, e.cycle, e.data);
        end
        checks++;
        if (wre4_cnt - w0 != 1) begin
            errors++; $display("FAIL rst_rearb_wre: got %0d pulses want 1", wre4_cnt - w0);
        end
    endtask

    task automatic test_drop();
        exp_t e;
        int k, extra;
        bit gi, gm;
        do_reset();
        push_exp(1'b0, 32'hA5A5_0002, 2);
        push_exp(1'b1, 32'hDEAD_BEEF, 3);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8;
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clock);
        mem_req = 1'b0;
        wait_ack(1'b0, 8, gi, gm, k);
        e = sb.pop_front();
        checks++;
        if (!gm || gi || k != e.cycle || mem_rdata1 !== e.data) begin
            errors++; $display("FAIL drop_mem_ack: got ack %b cycle %0d rdata %h want 1 %0d %h",
                               gm, k, mem_rdata1, e.cycle, e.data);
        end
        wait_ack(1'b0, 8, gi, gm, k);
        if_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!gi || gm || k != e.cycle || if_rdata1 !== e.data) begin
            errors++; $display("FAIL drop_next_if: got ack %b cycle %0d rdata %h want 1 %0d %h",
                               gi, k, if_rdata1, e.cycle, e.data);
        end
        extra = 0;
        repeat (5) begin
            @(negedge clock);
            if (if_ack1 || mem_ack1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL drop_no_extra: got %0d acks want 0", extra);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_write();
        test_starvation();
        test_latency4();
        test_reset_during_access();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
